// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered MIC datapath ALU with output shifter and iterative unsigned mul/div
module alu_mdu #(
  parameter int NBITS       = 32,
  parameter int ALU_CONTROL = 6,
  parameter int CNTW        = $clog2(NBITS) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ALU_CONTROL-1:0] alu_control,
  input  logic [1:0]             shift,
  input  logic [NBITS-1:0]       a,
  input  logic [NBITS-1:0]       b_bus,
  output logic [NBITS-1:0]       c,
  output logic                   n,
  output logic                   z,
  output logic                   dz,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ALU_CONTROL-1:0] F_A     = ALU_CONTROL'('h18);
  localparam logic [ALU_CONTROL-1:0] F_B     = ALU_CONTROL'('h14);
  localparam logic [ALU_CONTROL-1:0] F_NA    = ALU_CONTROL'('h1A);
  localparam logic [ALU_CONTROL-1:0] F_NB    = ALU_CONTROL'('h2C);
  localparam logic [ALU_CONTROL-1:0] F_ADD   = ALU_CONTROL'('h3C);
  localparam logic [ALU_CONTROL-1:0] F_ADD1  = ALU_CONTROL'('h3D);
  localparam logic [ALU_CONTROL-1:0] F_INCA  = ALU_CONTROL'('h39);
  localparam logic [ALU_CONTROL-1:0] F_INCB  = ALU_CONTROL'('h35);
  localparam logic [ALU_CONTROL-1:0] F_SUB   = ALU_CONTROL'('h3F);
  localparam logic [ALU_CONTROL-1:0] F_DECB  = ALU_CONTROL'('h37);
  localparam logic [ALU_CONTROL-1:0] F_NEGA  = ALU_CONTROL'('h3B);
  localparam logic [ALU_CONTROL-1:0] F_AND   = ALU_CONTROL'('h0C);
  localparam logic [ALU_CONTROL-1:0] F_OR    = ALU_CONTROL'('h1C);
  localparam logic [ALU_CONTROL-1:0] F_ZERO  = ALU_CONTROL'('h10);
  localparam logic [ALU_CONTROL-1:0] F_ONE   = ALU_CONTROL'('h11);
  localparam logic [ALU_CONTROL-1:0] F_MONE  = ALU_CONTROL'('h12);
  localparam logic [ALU_CONTROL-1:0] F_MUL   = ALU_CONTROL'('h20);
  localparam logic [ALU_CONTROL-1:0] F_DIVU  = ALU_CONTROL'('h21);
  localparam logic [ALU_CONTROL-1:0] F_REMU  = ALU_CONTROL'('h22);

  localparam logic [1:0] MOP_MUL  = 2'd0;
  localparam logic [1:0] MOP_DIVU = 2'd1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mop;
  logic [NBITS-1:0]  acc, quo, opd;
  logic [CNTW-1:0]   cnt;
  logic [NBITS-1:0]  alu_r, sh_r, mdu_res, div_rem;
  logic [NBITS:0]    rem_sh;
  logic              div_q, is_mdu;

  always_comb begin
    alu_r = a;
    case (alu_control)
      F_A:     alu_r = a;
      F_B:     alu_r = b_bus;
      F_NA:    alu_r = ~a;
      F_NB:    alu_r = ~b_bus;
      F_ADD:   alu_r = a + b_bus;
      F_ADD1:  alu_r = a + b_bus + NBITS'(1);
      F_INCA:  alu_r = a + NBITS'(1);
      F_INCB:  alu_r = b_bus + NBITS'(1);
      F_SUB:   alu_r = b_bus - a;
      F_DECB:  alu_r = b_bus - NBITS'(1);
      F_NEGA:  alu_r = -a;
      F_AND:   alu_r = a & b_bus;
      F_OR:    alu_r = a | b_bus;
      F_ZERO:  alu_r = '0;
      F_ONE:   alu_r = NBITS'(1);
      F_MONE:  alu_r = '1;
      default: alu_r = a;
    endcase
  end

  always_comb begin
    sh_r = alu_r;
    case (shift)
      2'b01:   sh_r = alu_r << 8;
      2'b10:   sh_r = {alu_r[NBITS-1], alu_r[NBITS-1:1]};
      default: sh_r = alu_r;
    endcase
  end

  assign is_mdu = (alu_control == F_MUL) || (alu_control == F_DIVU) || (alu_control == F_REMU);
  assign busy   = (state != IDLE);

  // Restoring division step; a zero divisor naturally yields quotient all ones and remainder a.
  assign rem_sh  = {acc, quo[NBITS-1]};
  assign div_q   = (rem_sh >= {1'b0, opd});
  assign div_rem = div_q ? NBITS'(rem_sh - {1'b0, opd}) : rem_sh[NBITS-1:0];
  assign mdu_res = (mop == MOP_DIVU) ? quo : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_mdu) state_nxt = RUN;
      RUN:     if (cnt == CNTW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c    <= '0;
      n    <= 1'b0;
      z    <= 1'b0;
      dz   <= 1'b0;
      done <= 1'b0;
      mop  <= MOP_MUL;
      acc  <= '0;
      quo  <= '0;
      opd  <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_mdu) begin
            mop <= alu_control[1:0];
            acc <= '0;
            cnt <= CNTW'(NBITS);
            // MUL: opd is the multiplicand, quo the multiplier; DIV: opd divisor, quo dividend.
            if (alu_control == F_MUL) begin
              opd <= a;
              quo <= b_bus;
            end else begin
              opd <= b_bus;
              quo <= a;
            end
          end else if (start) begin
            c    <= sh_r;
            n    <= sh_r[NBITS-1];
            z    <= (sh_r == '0);
            dz   <= 1'b0;
            done <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt - CNTW'(1);
          if (mop == MOP_MUL) begin
            if (quo[0]) acc <= acc + opd;
            opd <= opd << 1;
            quo <= quo >> 1;
          end else begin
            acc <= div_rem;
            quo <= {quo[NBITS-2:0], div_q};
          end
        end
        DONE: begin
          c    <= mdu_res;
          n    <= mdu_res[NBITS-1];
          z    <= (mdu_res == '0);
          dz   <= (mop != MOP_MUL) && (opd == '0);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - randomized self-checking bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    alu_control = '0;
  logic [1:0]    shift = '0;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b_bus = '0;
  logic [NB-1:0] c;
  logic          n, z, dz, busy, done;

  int checks = 0;
  int failures = 0;

  alu_mdu #(.NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control), .shift(shift),
    .a(a), .b_bus(b_bus), .c(c), .n(n), .z(z), .dz(dz), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] ref_single(input logic [5:0] code, input logic [1:0] sh,
                                               input logic [NB-1:0] x, input logic [NB-1:0] y);
    longint unsigned r;
    longint unsigned m;
    logic [NB-1:0] res;
    m = 64'd1 << NB;
    case (code)
      6'h18: r = x;
      6'h14: r = y;
      6'h1A: r = m - 1 - x;
      6'h2C: r = m - 1 - y;
      6'h3C: r = (x + y) % m;
      6'h3D: r = (x + y + 1) % m;
      6'h39: r = (x + 1) % m;
      6'h35: r = (y + 1) % m;
      6'h3F: r = (y + m - x) % m;
      6'h37: r = (y + m - 1) % m;
      6'h3B: r = (m - x) % m;
      6'h0C: r = x & y;
      6'h1C: r = x | y;
      6'h10: r = 0;
      6'h11: r = 1;
      6'h12: r = m - 1;
      default: r = x;
    endcase
    if (sh == 2'b01) r = (r * 256) % m;
    else if (sh == 2'b10) r = (r / 2) + ((r >= m / 2) ? m / 2 : 0);
    res = NB'(r);
    return res;
  endfunction

  task automatic issue(input logic [5:0] code, input logic [1:0] sh,
                       input logic [NB-1:0] x, input logic [NB-1:0] y);
    @(negedge clk);
    start = 1'b1; alu_control = code; shift = sh; a = x; b_bus = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_mdu(input logic [5:0] code, input logic [NB-1:0] x, input logic [NB-1:0] y,
                           input bit noisy, output int cyc, output int busy_bad);
    @(negedge clk);
    start = 1'b1; alu_control = code; shift = 2'($urandom); a = x; b_bus = y;
    @(negedge clk);
    start = 1'b0; cyc = 0; busy_bad = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_bad++;
      if (noisy) begin
        start = 1'($urandom); alu_control = 6'($urandom); a = $urandom; b_bus = $urandom;
      end
      if (cyc == NB) start = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({c, n, z, dz, busy, done} !== '0) begin
      failures++; $display("FAIL reset_state: got c=%h n%b z%b dz%b busy%b done%b, want all 0", c, n, z, dz, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL after_release: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_legacy;
    logic [5:0]    codes[5] = '{6'h3C, 6'h10, 6'h3F, 6'h18, 6'h05};
    logic [1:0]    shs[5]   = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [NB-1:0] as[5]    = '{32'd5, 32'd3, 32'd8, 32'h00123456, 32'hA5};
    logic [NB-1:0] bs[5]    = '{32'd7, 32'd9, 32'd3, 32'd0, 32'd0};
    logic [NB-1:0] exp_c[5] = '{32'h0000000C, 32'h0, 32'hFFFFFFFD, 32'h12345600, 32'hA5};
    logic          exp_n[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          exp_z[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [NB-1:0] e;
    logic [5:0]    code;
    logic [NB-1:0] x, y;
    logic [1:0]    sh;
    for (int i = 0; i < 5; i++) begin
      issue(codes[i], shs[i], as[i], bs[i]);
      checks++;
      if (c !== exp_c[i] || n !== exp_n[i] || z !== exp_z[i] || done !== 1'b1 || busy !== 1'b0 || dz !== 1'b0) begin
        failures++;
        $display("FAIL legacy_dir%0d: got c=%h n%b z%b done%b busy%b dz%b, want c=%h n%b z%b done1 busy0 dz0",
                 i, c, n, z, done, busy, dz, exp_c[i], exp_n[i], exp_z[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || c !== exp_c[i]) begin
        failures++; $display("FAIL legacy_hold%0d: got done=%b c=%h, want done0 c=%h", i, done, c, exp_c[i]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      code = 6'($urandom);
      if (code >= 6'h20 && code <= 6'h22) code = 6'h3B;
      x = (i % 5 == 0) ? 32'h0 : $urandom;
      y = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      sh = 2'($urandom);
      issue(code, sh, x, y);
      e = ref_single(code, sh, x, y);
      checks++;
      if (c !== e || n !== e[NB-1] || z !== (e == 0) || done !== 1'b1) begin
        failures++;
        $display("FAIL legacy_rand code=%h sh=%0d a=%h b=%h: got c=%h n%b z%b done%b, want c=%h", code, sh, x, y, c, n, z, done, e);
      end
    end
  endtask

  task automatic test_mdu_case(input logic [5:0] code, input logic [NB-1:0] x, input logic [NB-1:0] y,
                               input bit noisy);
    int cyc, bb;
    logic [NB-1:0] e;
    logic          edz;
    longint unsigned p;
    p = longint'(x) * longint'(y);
    edz = (code != 6'h20) && (y == 0);
    if (code == 6'h20) e = NB'(p);
    else if (code == 6'h21) e = (y == 0) ? '1 : x / y;
    else e = (y == 0) ? x : x % y;
    issue_mdu(code, x, y, noisy, cyc, bb);
    checks++;
    if (cyc !== NB + 1 || bb !== 0) begin
      failures++; $display("FAIL mdu_latency code=%h: got done after %0d edges, busy low %0d times, want %0d and 0", code, cyc, bb, NB + 1);
    end
    checks++;
    if (c !== e || dz !== edz || n !== e[NB-1] || z !== (e == 0) || busy !== 1'b0) begin
      failures++;
      $display("FAIL mdu_result code=%h a=%h b=%h: got c=%h dz%b n%b z%b busy%b, want c=%h dz%b", code, x, y, c, dz, n, z, busy, e, edz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || c !== e) begin
      failures++; $display("FAIL mdu_after code=%h: got done=%b busy=%b c=%h, want 0 0 %h", code, done, busy, c, e);
    end
  endtask

  task automatic test_mul;
    test_mdu_case(6'h20, 32'h00010000, 32'h00010001, 1'b1);
    for (int i = 0; i < 5; i++) test_mdu_case(6'h20, $urandom, $urandom >> $urandom_range(0, 31), i[0]);
  endtask

  task automatic test_div;
    logic [NB-1:0] y;
    test_mdu_case(6'h21, 32'd100, 32'd7, 1'b0);
    test_mdu_case(6'h22, 32'd100, 32'd7, 1'b1);
    test_mdu_case(6'h21, 32'hFFFFFFFF, 32'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      y = $urandom >> $urandom_range(0, 31);
      if (y == 0) y = 32'd3;
      test_mdu_case(i[0] ? 6'h22 : 6'h21, $urandom, y, i[1]);
    end
  endtask

  task automatic test_divzero;
    test_mdu_case(6'h21, 32'd9, 32'd0, 1'b0);
    test_mdu_case(6'h22, 32'd9, 32'd0, 1'b1);
    issue(6'h3C, 2'b00, 32'd2, 32'd3);
    checks++;
    if (dz !== 1'b0 || c !== 32'd5 || done !== 1'b1) begin
      failures++; $display("FAIL dz_clear: got dz=%b c=%h done=%b, want dz0 c=5 done1", dz, c, done);
    end
  endtask

  task automatic test_back_to_back;
    logic [NB-1:0] e, x, y;
    logic [5:0]    code;
    logic [1:0]    sh;
    @(negedge clk);
    e = '0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        checks++;
        if (c !== e || done !== 1'b1 || busy !== 1'b0) begin
          failures++; $display("FAIL b2b%0d: got c=%h done=%b busy=%b, want c=%h done1 busy0", i, c, done, busy, e);
        end
      end
      if (i < 20) begin
        code = 6'($urandom);
        if (code >= 6'h20 && code <= 6'h22) code = 6'h1C;
        x = $urandom; y = $urandom; sh = 2'($urandom);
        start = 1'b1; alu_control = code; shift = sh; a = x; b_bus = y;
        e = ref_single(code, sh, x, y);
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midop;
    int seen;
    issue(6'h3C, 2'b00, 32'd1, 32'd2);
    checks++;
    if (c !== 32'd3) begin
      failures++; $display("FAIL pre_reset: got c=%h, want 3", c);
    end
    @(negedge clk);
    start = 1'b1; alu_control = 6'h20; a = 32'h1234; b_bus = 32'h77;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({c, n, z, dz, busy, done} !== '0) begin
      failures++; $display("FAIL async_reset: got c=%h n%b z%b dz%b busy%b done%b, want all 0", c, n, z, dz, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL discarded_op: got %0d cycles with done/busy, want 0", seen);
    end
    issue(6'h3C, 2'b00, 32'd1, 32'd1);
    checks++;
    if (c !== 32'd2 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_add: got c=%h done=%b busy=%b, want 2 1 0", c, done, busy);
    end
  endtask

  initial begin
    test_reset;
    test_legacy;
    test_mul;
    test_div;
    test_divzero;
    test_back_to_back;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Registered successor to the single-cycle MIC datapath ALU. Width is parametrised.
- Keeps every legacy 6-bit ALU function, adds a MIC-1 style output shifter, and adds an iterative unsigned multiply/divide unit with a start/busy/done handshake.
- Sits between the A/B buses and the C bus. The microsequencer holds its next microinstruction while busy is high.

Parameters:
NBITS, 32, datapath width (must be at least 2)
ALU_CONTROL, 6, width of the function code
CNTW, $clog2(NBITS)+1, iteration counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  request; sampled only when busy=0
alu_control  in  ALU_CONTROL  function code, sampled with start
shift  in  2  output shifter select, sampled with start
a  in  NBITS  A operand, sampled with start
b_bus  in  NBITS  B operand, sampled with start
c  out  NBITS  registered result
n  out  1  registered negative flag, c[NBITS-1]
z  out  1  registered zero flag, c==0
dz  out  1  divide-by-zero flag of the last completed operation
busy  out  1  multi-cycle operation in progress
done  out  1  one-cycle pulse: c/n/z/dz were updated this cycle

Behaviour:
- Reset (rst_n=0, asynchronous, any state, including mid-operation):
  - FSM goes to IDLE.
  - c=0, n=0, z=0, dz=0, busy=0, done=0.
  - Internal accumulator, quotient and counter are cleared.
  - An in-flight operation is discarded and never reports done.
- Legacy functions, single cycle, latency 1:
  - 18 A; 14 B; 1A ~A; 2C ~B; 3C A+B; 3D A+B+1; 39 A+1; 35 B+1; 3F B-A; 37 B-1; 3B -A; 0C A&B; 1C A|B; 10 0; 11 1; 12 -1.
  - All arithmetic is modulo 2^NBITS. Carry-out is discarded.
  - Any unlisted code produces A.
- Shifter, applied only to single-cycle results:
  - 00: none.
  - 01: SLL8, logical left 8, zero fill.
  - 10: SRA1, arithmetic right 1.
  - 11: none.
  - n and z are computed after the shift.
- Multi-cycle functions, unsigned, shift field ignored:
  - 20 MUL: low NBITS of a*b_bus.
  - 21 DIVU: a/b_bus.
  - 22 REMU: a%b_bus.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - start=1 with a single-cycle code: at the next edge c/n/z are loaded, dz=0, done=1. FSM stays IDLE and busy stays 0.
  - start=1 with an MDU code: operands latch, counter loads NBITS, busy=1, FSM goes to RUN.
- RUN:
  - One shift-add step (MUL) or one restoring-division step (DIVU/REMU) per edge. Counter decrements each edge.
  - After NBITS steps (counter reaches 0) go to DONE.
- DONE:
  - c/n/z/dz are loaded, done=1, busy=0, FSM returns to IDLE.
  - done is therefore asserted exactly NBITS+1 edges after the edge that accepted start.
- Divide by zero (b_bus=0), for DIVU and REMU:
  - Same latency; dz=1.
  - DIVU gives c = all ones.
  - REMU gives c = a.
  - MUL always gives dz=0.
- start while busy=1 is ignored entirely: no queuing and no effect on the in-flight operation.
- A start on the same edge that DONE completes is ignored, because busy is still high in that cycle.
- Back-to-back single-cycle ops are accepted every cycle, and done stays high continuously.
- c/n/z/dz hold their value between done pulses. Operands may change freely after acceptance.
- done is never high while busy is high, and never high in the cycle after reset release unless start was accepted.

Test Plan (NBITS=32):
1. Reset, then start with 3C, a=5, b=7, shift=00 → next cycle c=0x0000000C, n=0, z=0, done=1 for 1 cycle, busy never high. Next, 10 → c=0, z=1.
2. start with 3F, a=8, b=3, shift=10 → c=0xFFFFFFFD, n=1. Then 18, a=0x00123456, shift=01 → c=0x12345600. Then unlisted code 05, a=0xA5 → c=0xA5.
3. start with 20, a=0x00010000, b=0x00010001 → busy high 33 cycles, done exactly 33 edges after start, c=0x00010000, dz=0. start pulses during busy have no effect, and the operand buses are changed during busy without affecting c.
4. DIVU a=100, b=7 → c=14. REMU with the same operands → c=2. DIVU a=0xFFFFFFFF, b=1 → c=0xFFFFFFFF, n=1.
5. DIVU a=9, b=0 → c=0xFFFFFFFF, dz=1, n=1, same 33-cycle latency. REMU a=9, b=0 → c=9, dz=1. The next 3C clears dz.
6. Drop rst_n asynchronously mid-MUL (cycle 10) → outputs clear immediately, with no done pulse. After release, 3C with a=1, b=1 → c=2 in 1 cycle.
